// File: rtl/tick_divider_8_bit.sv
// Programmable square-wave tick source: divides qzt_clk by 2*hp with a rising-edge strobe,
// running continuously or for a counted burst of periods.
module tick_divider_8_bit #(
    parameter int WIDTH = 8
) (
    input  logic             qzt_clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] halfPeriod,
    input  logic [WIDTH-1:0] pulseCount,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_reg;
    logic [WIDTH-1:0] hp_reg;
    logic [WIDTH-1:0] rem_reg;
    logic             armed_reg;
    logic             cont_reg;

    assign busy = (state_reg != IDLE);

    always_ff @(posedge qzt_clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            hp_reg    <= ONE;
            rem_reg   <= '0;
            armed_reg <= 1'b0;
            cont_reg  <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (load) begin
                // A zero half-period would never reload, so it is clamped to one cycle.
                hp_reg    <= (halfPeriod == '0) ? ONE : halfPeriod;
                rem_reg   <= pulseCount;
                cont_reg  <= (pulseCount == '0);
                armed_reg <= 1'b1;
                state_reg <= IDLE;
                clk_out   <= 1'b0;
                count     <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (enable && armed_reg) begin
                            state_reg <= HIGH;
                            clk_out   <= 1'b1;
                            tick      <= 1'b1;
                            count     <= hp_reg - ONE;
                        end
                    end
                    HIGH: begin
                        if (count != '0) begin
                            count <= count - ONE;
                        end else begin
                            state_reg <= LOW;
                            clk_out   <= 1'b0;
                            count     <= hp_reg - ONE;
                        end
                    end
                    LOW: begin
                        if (count != '0) begin
                            count <= count - ONE;
                        end else if (!cont_reg && rem_reg == ONE) begin
                            rem_reg   <= '0;
                            armed_reg <= 1'b0;
                            state_reg <= IDLE;
                            clk_out   <= 1'b0;
                            done      <= 1'b1;
                        end else if (!enable) begin
                            // Stop only at a period boundary so no phase is ever truncated.
                            state_reg <= IDLE;
                            clk_out   <= 1'b0;
                            if (!cont_reg) rem_reg <= rem_reg - ONE;
                        end else begin
                            if (!cont_reg) rem_reg <= rem_reg - ONE;
                            state_reg <= HIGH;
                            clk_out   <= 1'b1;
                            tick      <= 1'b1;
                            count     <= hp_reg - ONE;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        clk_out   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tick_divider_8_bit.md
Name: tick_divider_8_bit

Overview:
- Programmable tick source that drives the edge-detected clk_in inputs of the synchro counters (e.g. pixel/line counters in vga_test).
- Divides qzt_clk into a 50% duty square wave clk_out with a programmable half-period, plus a one-cycle tick strobe per rising edge.
- Supports continuous running or a counted burst of N periods, with busy/done status.

Parameters:
WIDTH, 8, width of halfPeriod, pulseCount and the internal down-counters.

Ports:
qzt_clk  input  1  system clock; all logic on its rising edge
reset  input  1  asynchronous, active-high reset
load  input  1  latch halfPeriod/pulseCount and arm the block; aborts any running output
enable  input  1  level run request; sampled each qzt_clk
halfPeriod  input  WIDTH  clk_out high/low phase length in qzt_clk cycles; 0 treated as 1
pulseCount  input  WIDTH  number of clk_out periods per burst; 0 = continuous
clk_out  output  1  divided square wave, registered
tick  output  1  one-cycle strobe, coincident with each clk_out 0->1 transition
busy  output  1  1 while in HIGH or LOW state
done  output  1  one-cycle strobe when a counted burst completes
count  output  WIDTH  current phase down-counter value

Behaviour:
- Reset (async, any time): state IDLE, clk_out=0, tick=0, busy=0, done=0, count=0, hp_reg=1, rem_reg=0, armed=0, cont=0.
- States: IDLE, HIGH, LOW. busy = (state != IDLE). tick and done default to 0 every cycle.
- load has priority over everything, in any state:
  - hp_reg = (halfPeriod==0) ? 1 : halfPeriod; rem_reg = pulseCount; cont = (pulseCount==0); armed = 1.
  - Next state IDLE, clk_out=0, count=0, no tick, no done.
- IDLE with !load, enable=1, armed=1: next state HIGH, clk_out=1, tick=1, count=hp_reg-1.
- IDLE otherwise: hold all outputs. Before the first load after reset nothing runs.
- HIGH:
  - count!=0: count-1.
  - count==0: next state LOW, clk_out=0, count=hp_reg-1.
- LOW with count!=0: count-1.
- LOW with count==0 (end of a full period), checked in this order:
  - !cont and rem_reg==1: rem_reg=0, armed=0, next state IDLE, clk_out=0, done=1.
  - enable==0: next state IDLE, clk_out=0, no done; rem_reg decremented if !cont; armed kept.
  - Otherwise: rem_reg decremented if !cont; next state HIGH, clk_out=1, tick=1, count=hp_reg-1.
- Timing rules:
  - Period = 2*hp_reg cycles. The first rising edge appears in the cycle after enable is sampled high (registered).
  - hp_reg=1 gives clk_out toggling every cycle (qzt_clk/2).
- Glitch-free stop: dropping enable mid-period finishes the current full period and never truncates a phase. Re-asserting enable later resumes with the remaining count.
- halfPeriod/pulseCount changes are ignored until the next load.
- Simultaneous load and enable: load wins, and the block starts on the following cycle if enable is still high.
- After a completed burst (armed=0), enable does nothing until a new load.
- count wraps are impossible: reload happens only at 0.

Test Plan:
- Reset mid-HIGH with hp=4 continuous -> clk_out, busy, tick, count all 0 immediately (async), no done; enable held high gives no output until a new load.
- load hp=3, N=2, then enable=1 -> clk_out 1,1,1,0,0,0,1,1,1,0,0,0 over 12 cycles; tick on cycles 1 and 7; done=1 on cycle 13 with busy=0; further enable gives no output.
- load hp=0, N=0, enable=1 -> clk_out toggles every cycle (treated as hp=1), tick every 2 cycles, done never asserts over 100 cycles.
- Continuous hp=5; drop enable at cycle 2 of HIGH -> HIGH completes 5 cycles, LOW completes 5 cycles, then IDLE, no done; re-enable restarts with a tick.
- load during LOW of an N=4 burst (hp=2) -> next cycle IDLE, clk_out=0, no done; with enable high, a fresh burst starts with new values on the following cycle.
- load and enable asserted together in IDLE -> no tick that cycle; HIGH and tick appear exactly one cycle later.
